// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        FLUSH,
        DONE,
        ERR
    } loader_state_t;

    localparam int LenBytes  = 2;
    localparam int WordBytes = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready handshake between a stream source and the loader.
interface instr_loader_if;

    logic       byte_valid_i;
    logic [7:0] byte_data_i;
    logic       byte_ready_o;

    modport master (output byte_valid_i, output byte_data_i, input byte_ready_o);
    modport slave  (input byte_valid_i, input byte_data_i, output byte_ready_o);

endinterface

// File: rtl/instr_loader.sv
// Packs a length-prefixed little-endian byte stream into instruction words
// and writes them to imem from address 0, holding the core in reset until done.
//
// state  | meaning
// LEN_LO | waiting for word-count low byte
// LEN_HI | waiting for word-count high byte; validates the count
// DATA   | packing bytes, one imem write per four bytes
// FLUSH  | final write strobe in flight, stream paused
// DONE   | load complete, core released
// ERR    | word count exceeds capacity, core held in reset
module instr_loader
    import loader_pkg::*;
#(
    parameter int AddressWidth = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    instr_loader_if.slave           stream,
    output logic                    imem_wr_en_o,
    output logic [AddressWidth-1:0] imem_wr_addr_o,
    output logic [31:0]             imem_wr_data_o,
    output logic                    cpu_rst_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [15:0]             words_loaded_o
);

    localparam logic [16:0] Capacity = 17'(1) << (AddressWidth - 2);
    localparam logic [AddressWidth-3:0] PtrOne = {{(AddressWidth-3){1'b0}}, 1'b1};

    loader_state_t state_q, state_d;

    logic [15:0]             len_q;
    logic [15:0]             words_q;
    logic [AddressWidth-3:0] wr_ptr_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             word_q;
    logic                    wr_en_q;
    logic [AddressWidth-1:0] wr_addr_q;
    logic [31:0]             wr_data_q;

    logic        xfer;
    logic        last_byte;
    logic        last_word;
    logic [15:0] len_full;

    assign xfer      = stream.byte_valid_i & stream.byte_ready_o;
    assign last_byte = (byte_cnt_q == 2'(WordBytes - 1));
    assign last_word = ((words_q + 16'd1) == len_q);
    assign len_full  = {stream.byte_data_i, len_q[7:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LEN_LO: if (xfer) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > Capacity) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA:   if (xfer && last_byte && last_word) state_d = FLUSH;
            FLUSH:  state_d = DONE;
            DONE:   state_d = DONE;
            ERR:    state_d = ERR;
            default: state_d = LEN_LO;
        endcase
    end

    always_comb begin
        stream.byte_ready_o = 1'b0;
        cpu_rst_o           = 1'b1;
        done_o              = 1'b0;
        err_o               = 1'b0;
        unique case (state_q)
            LEN_LO, LEN_HI, DATA: stream.byte_ready_o = 1'b1;
            DONE: begin
                done_o    = 1'b1;
                cpu_rst_o = 1'b0;
            end
            ERR:     err_o = 1'b1;
            default: ;
        endcase
    end

    // Separate address pointer avoids slicing the 16-bit word count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            words_q    <= '0;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (xfer) begin
                unique case (state_q)
                    LEN_LO: len_q[7:0]  <= stream.byte_data_i;
                    LEN_HI: len_q[15:8] <= stream.byte_data_i;
                    DATA: begin
                        if (last_byte) begin
                            wr_data_q  <= {stream.byte_data_i, word_q};
                            wr_addr_q  <= {wr_ptr_q, 2'b00};
                            wr_en_q    <= 1'b1;
                            words_q    <= words_q + 16'd1;
                            wr_ptr_q   <= wr_ptr_q + PtrOne;
                            byte_cnt_q <= '0;
                        end else begin
                            case (byte_cnt_q)
                                2'd0:    word_q[7:0]   <= stream.byte_data_i;
                                2'd1:    word_q[15:8]  <= stream.byte_data_i;
                                default: word_q[23:16] <= stream.byte_data_i;
                            endcase
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_wr_en_o   = wr_en_q;
    assign imem_wr_addr_o = wr_addr_q;
    assign imem_wr_data_o = wr_data_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table plus hand-written corner sequences.
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    instr_loader_if stream();

    instr_loader #(.AddressWidth(10)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stream         (stream.slave),
        .imem_wr_en_o   (imem_wr_en),
        .imem_wr_addr_o (imem_wr_addr),
        .imem_wr_data_o (imem_wr_data),
        .cpu_rst_o      (cpu_rst),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] len;
        int          n_words;
        bit          throttle;
        bit          exp_err;
        logic [31:0] w [4];
    } vec_t;

    wr_t         sb_q[$];
    int          checks = 0;
    int          passes = 0;
    int          strobes = 0;
    logic [9:0]  last_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            strobes++;
            last_addr = imem_wr_addr;
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {22'd0, imem_wr_addr, imem_wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
                chk("wr_data", 64'(imem_wr_data), 64'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stream.byte_valid_i = 1'b0;
        stream.byte_data_i  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        strobes = 0;
        chk("rst_ready",   64'(stream.byte_ready_o), 64'd1);
        chk("rst_wr_en",   64'(imem_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(imem_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(imem_wr_data), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_done",    64'(done), 64'd0);
        chk("rst_err",     64'(err), 64'd0);
        chk("rst_words",   64'(words_loaded), 64'd0);
    endtask

    // Presents a byte at the falling edge; ok reports whether it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit throttle, output bit ok);
        if (throttle) begin
            @(negedge clk);
            stream.byte_valid_i = 1'b0;
            stream.byte_data_i  = 8'($urandom_range(0, 255));
            @(posedge clk);
        end
        @(negedge clk);
        stream.byte_valid_i = 1'b1;
        stream.byte_data_i  = b;
        ok = stream.byte_ready_o;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        stream.byte_valid_i = 1'b0;
        stream.byte_data_i  = 8'h5A;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input bit throttle);
        bit ok;
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.addr = 10'(idx * 4);
                e.data = w;
                sb_q.push_back(e);
            end
            send_byte(w[8*k +: 8], throttle, ok);
            chk("data_accept", 64'(ok), 64'd1);
        end
    endtask

    task automatic send_len(input logic [15:0] len, input bit throttle);
        bit ok;
        send_byte(len[7:0], throttle, ok);
        chk("len_lo_accept", 64'(ok), 64'd1);
        send_byte(len[15:8], throttle, ok);
        chk("len_hi_accept", 64'(ok), 64'd1);
    endtask

    vec_t vecs [6];

    initial begin
        bit ok;
        rst = 1'b1;
        stream.byte_valid_i = 1'b0;
        stream.byte_data_i  = 8'h00;

        vecs[0] = '{"two_word",   16'd2,   2, 1'b0, 1'b0, '{32'h00100513, 32'h00200593, 32'h0, 32'h0}};
        vecs[1] = '{"zero_len",   16'd0,   0, 1'b0, 1'b0, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[2] = '{"over_cap",   16'd257, 0, 1'b0, 1'b1, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[3] = '{"throttled",  16'd2,   2, 1'b1, 1'b0, '{32'h00100513, 32'h00200593, 32'h0, 32'h0}};
        vecs[4] = '{"four_word",  16'd4,   4, 1'b0, 1'b0, '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF}};
        vecs[5] = '{"big_len_err", 16'h8000, 0, 1'b1, 1'b1, '{32'h0, 32'h0, 32'h0, 32'h0}};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_len(vecs[v].len, vecs[v].throttle);
            for (int i = 0; i < vecs[v].n_words; i++) begin
                send_word(i, vecs[v].w[i], vecs[v].throttle);
            end
            idle();
            if (vecs[v].exp_err) begin
                chk({vecs[v].name, "_err"},     64'(err), 64'd1);
                chk({vecs[v].name, "_ready"},   64'(stream.byte_ready_o), 64'd0);
                chk({vecs[v].name, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
                chk({vecs[v].name, "_done"},    64'(done), 64'd0);
            end else if (vecs[v].n_words == 0) begin
                chk({vecs[v].name, "_done"},    64'(done), 64'd1);
                chk({vecs[v].name, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
            end else begin
                chk({vecs[v].name, "_strobe_pre_done"}, 64'({imem_wr_en, done, cpu_rst}), 64'b101);
                @(negedge clk);
                chk({vecs[v].name, "_done_after_strobe"}, 64'({imem_wr_en, done, cpu_rst}), 64'b010);
            end
            send_byte(8'hA5, 1'b0, ok);
            chk({vecs[v].name, "_extra_rejected"}, 64'(ok), 64'd0);
            idle();
            repeat (3) @(negedge clk);
            chk({vecs[v].name, "_words"},    64'(words_loaded), vecs[v].exp_err ? 64'd0 : 64'(vecs[v].len));
            chk({vecs[v].name, "_strobes"},  64'(strobes), 64'(vecs[v].n_words));
            chk({vecs[v].name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        end

        // Reset after two data bytes, asserted while a third byte is offered.
        do_reset();
        send_len(16'd2, 1'b0);
        send_byte(8'h13, 1'b0, ok);
        send_byte(8'h05, 1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        stream.byte_valid_i = 1'b1;
        stream.byte_data_i  = 8'h10;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stream.byte_valid_i = 1'b0;
        chk("midword_no_strobe", 64'(strobes), 64'd0);
        chk("midword_words",     64'(words_loaded), 64'd0);
        chk("midword_ready",     64'(stream.byte_ready_o), 64'd1);
        send_len(16'd1, 1'b0);
        send_word(0, 32'h0000006F, 1'b0);
        idle();
        @(negedge clk);
        chk("midword_done",    64'(done), 64'd1);
        chk("midword_strobes", 64'(strobes), 64'd1);
        chk("midword_words2",  64'(words_loaded), 64'd1);

        // Exact capacity: 256 words fill the 1 KiB memory.
        do_reset();
        send_len(16'd256, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_word(i, 32'h1357_0000 ^ (32'(i) * 32'h0001_0203), 1'b0);
        end
        idle();
        chk("full_pre_done", 64'({imem_wr_en, done}), 64'b10);
        @(negedge clk);
        chk("full_done",      64'({done, cpu_rst}), 64'b10);
        chk("full_last_addr", 64'(last_addr), 64'h3FC);
        chk("full_strobes",   64'(strobes), 64'd256);
        chk("full_words",     64'(words_loaded), 64'd256);
        chk("full_sb_empty",  64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
        $fatal(1, "watchdog");
    end

endmodule
